conv_addr_sequencer: RTL
========================

# conv_addr_sequencer

Controller that sequences a 1-D convolution Z = X * Y across shared X/Y/Z memories and one MAC datapath. After a start pulse, it walks the output index i from 0 to size_x+size_y-2. For each i it walks the valid tap index k and issues one X/Y read-address pair per cycle, plus accumulator-clear and result-write strobes. It sits between the register/start interface and the memory + MAC datapath built from the team's counter, adder, mux and register blocks.

## Interface
- ADDR_WIDTH, 5, width of X/Y addresses and of size inputs; Z address is ADDR_WIDTH+1 bits
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- start_in  in  1  start request, sampled only in IDLE
- size_x_in  in  ADDR_WIDTH  length of X (0..2^ADDR_WIDTH-1)
- size_y_in  in  ADDR_WIDTH  length of Y (0..2^ADDR_WIDTH-1)
- busy_out  out  1  high from the cycle after accepted start until DONE inclusive
- done_out  out  1  one-cycle pulse in DONE
- addr_x_out  out  ADDR_WIDTH  X read address k
- addr_y_out  out  ADDR_WIDTH  Y read address i-k
- mac_valid_out  out  1  current X/Y address pair is a valid tap
- first_tap_out  out  1  with mac_valid_out: first tap of output i (accumulator loads instead of adds)
- addr_z_out  out  ADDR_WIDTH+1  Z write address i
- write_z_out  out  1  write accumulated result to Z[addr_z_out]

## Operation
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE: if start_in=1, latch sizes and set i=0.
  - If either size is 0, go to DONE.
  - Otherwise go to LOAD.
- LOAD: compute k_start = max(0, i-(size_y-1)) and k_end = min(i, size_x-1); set k=k_start; go to MAC. All outputs except busy are low.
- MAC: one tap per cycle.
  - Drive mac_valid_out=1, addr_x_out=k, addr_y_out=i-k.
  - first_tap_out=1 only when k==k_start.
  - If k==k_end, go to WRITE; else k++.
- WRITE: write_z_out=1 and addr_z_out=i for one cycle.
  - If i==size_x+size_y-2, go to DONE; else i++ and go to LOAD.
- DONE: done_out=1 for one cycle, then IDLE.
- Output length N = size_x+size_y-1, computed in ADDR_WIDTH+1 bits with no overflow.
- Index i uses ADDR_WIDTH+1 bits and never wraps.
- i-k is always in [0, size_y-1].
- start_in while busy is ignored. Size inputs are don't-care after acceptance.
- Reset (including mid-operation) forces IDLE. All outputs go to 0, including busy_out, done_out, addresses and strobes.
- Address outputs are 0 whenever their qualifying strobe is low.

## Timing
- All outputs are registered-state decodes with no combinational path from inputs to outputs.
- Cycles per output i: 1 (LOAD) + taps(i) + 1 (WRITE).
- Total busy cycles: 2N + size_x·size_y + 1 (the +1 is DONE). With a zero size, busy covers the DONE cycle only.
- Start sampled at edge E: busy_out is high from edge E+1.
- A write follows the last MAC of that output on the very next cycle. The datapath must therefore produce the accumulated result with ≤1 cycle latency from the last tap.
- A new start is accepted no earlier than the IDLE cycle after DONE.

## Configuration
- CONV_SEQ_STALL_EN defined:
  - Adds input stall_in (1 bit).
  - While stall_in=1, state, i and k hold and all strobes (mac_valid_out, first_tap_out, write_z_out, done_out) are forced to 0.
  - busy_out stays high. Addresses hold their last values.
  - Operation resumes on the first cycle with stall_in=0.
- Not defined: no stall_in port; the sequence always runs at full rate.

## Test plan
- Reset, no start: all outputs are 0. Pulse start with size_x=3, size_y=2. Required response:
  - (k, i-k) pairs are (0,0) | (0,1),(1,0) | (1,1),(2,0) | (2,1).
  - write_z_out fires for Z addresses 0,1,2,3.
  - busy_out lasts 15 cycles; done_out pulses once, on the 15th.
- size_x=1, size_y=1: one MAC (0,0) with first_tap_out=1, one write to Z[0], done_out at cycle 4.
- size_x=0, size_y=5: no MAC or write strobe; done_out pulses the cycle after start.
- start_in held high throughout a size 4x4 run: exactly one run (16 taps, 7 writes); a second run starts only after DONE.
- Assert rstn low during MAC of i=2 in a 5x3 run: outputs are 0 immediately. A new start after release restarts from i=0.
- With CONV_SEQ_STALL_EN, run 3x2 with stall_in high for 3 cycles during the second MAC: the tap sequence is identical, no strobes occur while stalled, and busy extends to 18 cycles.

Source files
------------

// File: rtl/conv_addr_sequencer.sv
// Address/strobe sequencer for a 1-D convolution Z = X * Y over shared X/Y/Z memories.
// Optional stall support is enabled with `define CONV_SEQ_STALL_EN (adds stall_in).
module conv_addr_sequencer #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] size_x_in,
  input  logic [ADDR_WIDTH-1:0] size_y_in,
`ifdef CONV_SEQ_STALL_EN
  input  logic                  stall_in,
`endif
  output logic                  busy_out,
  output logic                  done_out,
  output logic [ADDR_WIDTH-1:0] addr_x_out,
  output logic [ADDR_WIDTH-1:0] addr_y_out,
  output logic                  mac_valid_out,
  output logic                  first_tap_out,
  output logic [ADDR_WIDTH:0]   addr_z_out,
  output logic                  write_z_out
);

  localparam int ZW = ADDR_WIDTH + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_sx, r_sy;
  logic [ZW-1:0]         r_i, r_last;
  logic [ADDR_WIDTH-1:0] r_k, r_kstart, r_kend;

  logic                  w_run;
  logic [ZW-1:0]         w_symin1;
  logic [ADDR_WIDTH-1:0] w_sxmin1, w_kstart, w_kend;

`ifdef CONV_SEQ_STALL_EN
  assign w_run = ~stall_in;
`else
  assign w_run = 1'b1;
`endif

  // Valid tap window for output i: k in [max(0, i-(sy-1)), min(i, sx-1)]
  assign w_symin1 = {1'b0, r_sy} - ZW'(1);
  assign w_sxmin1 = r_sx - ADDR_WIDTH'(1);
  assign w_kstart = (r_i >= w_symin1) ? ADDR_WIDTH'(r_i - w_symin1) : '0;
  assign w_kend   = (r_i < {1'b0, w_sxmin1}) ? ADDR_WIDTH'(r_i) : w_sxmin1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_sx     <= '0;
      r_sy     <= '0;
      r_i      <= '0;
      r_last   <= '0;
      r_k      <= '0;
      r_kstart <= '0;
      r_kend   <= '0;
    end else if (w_run) begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_sx    <= size_x_in;
            r_sy    <= size_y_in;
            r_i     <= '0;
            r_last  <= {1'b0, size_x_in} + {1'b0, size_y_in} - ZW'(2);
            r_state <= (size_x_in == '0 || size_y_in == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          r_k      <= w_kstart;
          r_kstart <= w_kstart;
          r_kend   <= w_kend;
          r_state  <= S_MAC;
        end
        S_MAC: begin
          if (r_k == r_kend) r_state <= S_WRITE;
          else               r_k     <= r_k + ADDR_WIDTH'(1);
        end
        S_WRITE: begin
          if (r_i == r_last) begin
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i + ZW'(1);
            r_state <= S_LOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; stall can only mask strobes.
  always_comb begin
    busy_out      = (r_state != S_IDLE);
    done_out      = (r_state == S_DONE) && w_run;
    mac_valid_out = (r_state == S_MAC) && w_run;
    first_tap_out = (r_state == S_MAC) && w_run && (r_k == r_kstart);
    write_z_out   = (r_state == S_WRITE) && w_run;
    addr_x_out    = '0;
    addr_y_out    = '0;
    addr_z_out    = '0;
    if (r_state == S_MAC) begin
      addr_x_out = r_k;
      addr_y_out = ADDR_WIDTH'(r_i - {1'b0, r_k});
    end
    if (r_state == S_WRITE) addr_z_out = r_i;
  end

endmodule
